ssp_rx_fifo: RTL and testbench
==============================

# ssp_rx_fifo

Receive FIFO of the SSP: buffers bytes assembled by the serial receive logic until the processor reads them over the APB-style bus. It is the serial-to-parallel counterpart of the SSP transmit FIFO. The block asserts SSPRXINTR while full, drops and flags bytes that arrive when no slot is free, and presents the oldest byte on PRDATA with first-word fall-through.

## Interface
Parameters:
- WIDTH, 8: data width in bits.
- DEPTH, 4: number of entries; must be a power of two, ≥ 2.

Ports:
- PCLK  in  1  SSP clock; all state updates on rising edge.
- CLEAR_B  in  1  asynchronous, active-low reset.
- PSEL  in  1  chip select; processor accesses count only when high.
- PWRITE  in  1  0 = processor read (pop); 1 = write access, ignored by this block.
- RxDATA  in  WIDTH  byte from receive logic.
- LOGICREAD  in  1  one-cycle strobe: receive logic pushes RxDATA.
- PRDATA  out  WIDTH  head entry (oldest byte); 0 when empty.
- SSPRXINTR  out  1  high while FIFO holds DEPTH entries.
- EMPTY  out  1  high while FIFO holds 0 entries.
- OVERRUN  out  1  sticky: a push was dropped because FIFO was full.

## Operation
- Reset (CLEAR_B low, any time, asynchronous): W_PTR=0, R_PTR=0, count=0, OVERRUN=0, storage cleared to 0. Outputs: PRDATA=0, SSPRXINTR=0, EMPTY=1, OVERRUN=0. Reset mid-transfer discards all contents; no partial state survives.
- pop = PSEL & ~PWRITE & ~EMPTY. Read on empty is ignored: no pointer move, no flag change.
- push = LOGICREAD & (~full | pop). A push while full is accepted only when a pop occurs in the same cycle.
- Dropped push (LOGICREAD & full & ~pop): data discarded, pointers unchanged, OVERRUN←1.
- OVERRUN clears on the next pop when no drop occurs in that cycle. Drop wins when both happen in the same cycle. Reset also clears it.
- Push: mem[W_PTR]←RxDATA, W_PTR←W_PTR+1 (mod DEPTH).
- Pop: R_PTR←R_PTR+1 (mod DEPTH).
- count: +1 on push only, −1 on pop only, unchanged on both or neither. count is $clog2(DEPTH+1) bits and stays within 0..DEPTH.
- Flags are decoded from count: full = (count==DEPTH), EMPTY = (count==0), SSPRXINTR = full.
- Simultaneous push+pop on empty is impossible, because pop requires ~EMPTY.
- Pointer wrap is natural modulo DEPTH; full and empty are disambiguated only by count.

## Timing
- Push at edge k: byte is visible on PRDATA (if FIFO was empty), EMPTY falls, and count/flags update, all right after edge k. Latency is 1 cycle from LOGICREAD to data available.
- PRDATA is combinational from mem[R_PTR], gated by EMPTY. The processor samples it in the same cycle it asserts pop. After the pop edge, PRDATA shows the next entry or 0.
- SSPRXINTR rises the cycle after the push that fills the FIFO. It falls the cycle after the first pop from full, unless a push occurs in that same cycle, in which case it stays high.
- OVERRUN rises the cycle after the dropped push.
- No combinational path from inputs to SSPRXINTR, EMPTY or OVERRUN; these are functions of registers only.

## Structure
- Shared package ssp_pkg holds:
  - SSP_DATA_W=8
  - SSP_FIFO_DEPTH=4
  - localparam-style helper for pointer width ($clog2(SSP_FIFO_DEPTH))
- The transmit FIFO uses the same package constants.
- Single module with no sub-module. Storage is a register array, because async reset clears it.

## Test plan
- Reset then idle: PRDATA=0x00, EMPTY=1, SSPRXINTR=0, OVERRUN=0. Assert CLEAR_B low between edges → outputs return to these values immediately.
- Push 0xA1,0xB2,0xC3,0xD4 → SSPRXINTR=1 after 4th edge. Pop 4× with PSEL=1, PWRITE=0 → PRDATA reads A1,B2,C3,D4 in order, then EMPTY=1, PRDATA=0.
- Fill to full, then push 0xEE with no pop → 0xEE dropped, OVERRUN=1, contents unchanged. Next pop returns the original head and OVERRUN=0.
- Full, then same-cycle push 0x55 and pop → head popped, 0x55 stored at tail, SSPRXINTR stays 1, OVERRUN stays 0.
- Wrap: push/pop 10 bytes 0x01..0x0A, interleaving up to 3 outstanding → every byte read in order; pointers wrap correctly.
- Pop on empty and PSEL=0/PWRITE=1 accesses → no state change, EMPTY stays 1.

Source files
------------

// File: rtl/ssp_pkg.sv
// Shared SSP constants used by the receive and transmit FIFOs.
// Data width, FIFO depth and the derived pointer width.
package ssp_pkg;

    localparam int SSP_DATA_W     = 8;
    localparam int SSP_FIFO_DEPTH = 4;
    localparam int SSP_PTR_W      = $clog2(SSP_FIFO_DEPTH);

endpackage

// File: rtl/ssp_rx_fifo.sv
// SSP receive FIFO: buffers received bytes for the processor.
// First-word fall-through head, full interrupt, sticky overrun.
module ssp_rx_fifo
    import ssp_pkg::*;
#(
    parameter int WIDTH = SSP_DATA_W,
    parameter int DEPTH = SSP_FIFO_DEPTH
) (
    input  logic             PCLK,
    input  logic             CLEAR_B,
    input  logic             PSEL,
    input  logic             PWRITE,
    input  logic [WIDTH-1:0] RxDATA,
    input  logic             LOGICREAD,
    output logic [WIDTH-1:0] PRDATA,
    output logic             SSPRXINTR,
    output logic             EMPTY,
    output logic             OVERRUN
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    w_ptr;
    logic [PW-1:0]    r_ptr;
    logic [CW-1:0]    count;
    logic             ovr_q;
    logic             full;
    logic             pop;
    logic             push;
    logic             drop;

    // Flags and handshake qualifiers decoded from the occupancy count.
    always_comb begin
        full      = (count == CW'(DEPTH));
        EMPTY     = (count == '0);
        SSPRXINTR = full;
        OVERRUN   = ovr_q;
        pop       = PSEL & ~PWRITE & ~EMPTY;
        push      = LOGICREAD & (~full | pop);
        drop      = LOGICREAD & full & ~pop;
        PRDATA    = EMPTY ? '0 : mem[r_ptr];
    end

    // Pointers, occupancy count and sticky overrun flag.
    always_ff @(posedge PCLK or negedge CLEAR_B) begin
        if (!CLEAR_B) begin
            w_ptr <= '0;
            r_ptr <= '0;
            count <= '0;
            ovr_q <= 1'b0;
        end else begin
            if (push)
                w_ptr <= w_ptr + PW'(1);
            if (pop)
                r_ptr <= r_ptr + PW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (drop)
                ovr_q <= 1'b1;
            else if (pop)
                ovr_q <= 1'b0;
        end
    end

    // Storage array; cleared on reset so no stale byte survives.
    always_ff @(posedge PCLK or negedge CLEAR_B) begin
        if (!CLEAR_B) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (push) begin
            mem[w_ptr] <= RxDATA;
        end
    end

endmodule

// File: tb/tb_ssp_rx_fifo.sv
// Directed testbench for ssp_rx_fifo.
// Inputs change on the falling edge; outputs sampled there too.
module tb_ssp_rx_fifo;

    logic       PCLK;
    logic       CLEAR_B;
    logic       PSEL;
    logic       PWRITE;
    logic [7:0] RxDATA;
    logic       LOGICREAD;
    logic [7:0] PRDATA;
    logic       SSPRXINTR;
    logic       EMPTY;
    logic       OVERRUN;

    int n_vec;
    int n_err;

    ssp_rx_fifo #(.WIDTH(8), .DEPTH(4)) dut (
        .PCLK      (PCLK),
        .CLEAR_B   (CLEAR_B),
        .PSEL      (PSEL),
        .PWRITE    (PWRITE),
        .RxDATA    (RxDATA),
        .LOGICREAD (LOGICREAD),
        .PRDATA    (PRDATA),
        .SSPRXINTR (SSPRXINTR),
        .EMPTY     (EMPTY),
        .OVERRUN   (OVERRUN)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        @(negedge PCLK);
        LOGICREAD = 1'b0;
        PSEL      = 1'b0;
        PWRITE    = 1'b0;
        RxDATA    = 8'h00;
    endtask

    task automatic push(input logic [7:0] b);
        LOGICREAD = 1'b1;
        RxDATA    = b;
        step();
    endtask

    task automatic pop(input string tag, input logic [7:0] exp);
        PSEL   = 1'b1;
        PWRITE = 1'b0;
        check(tag, PRDATA, exp);
        step();
    endtask

    task automatic push_pop(input string tag, input logic [7:0] b,
                            input logic [7:0] exp);
        LOGICREAD = 1'b1;
        RxDATA    = b;
        PSEL      = 1'b1;
        PWRITE    = 1'b0;
        check(tag, PRDATA, exp);
        step();
    endtask

    task automatic idle_flags(input string tag);
        check({tag, "_prdata"}, PRDATA, 0);
        check({tag, "_empty"}, EMPTY, 1);
        check({tag, "_intr"}, SSPRXINTR, 0);
        check({tag, "_ovr"}, OVERRUN, 0);
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        CLEAR_B   = 1'b0;
        PSEL      = 1'b0;
        PWRITE    = 1'b0;
        RxDATA    = 8'h00;
        LOGICREAD = 1'b0;
        repeat (2) @(negedge PCLK);
        CLEAR_B = 1'b1;
        @(negedge PCLK);
        idle_flags("rst");

        // Fill and drain in order.
        push(8'hA1);
        check("fill1_data", PRDATA, 8'hA1);
        check("fill1_empty", EMPTY, 0);
        push(8'hB2);
        push(8'hC3);
        check("fill3_intr", SSPRXINTR, 0);
        push(8'hD4);
        check("fill4_intr", SSPRXINTR, 1);
        pop("rd_a1", 8'hA1);
        check("pop1_intr", SSPRXINTR, 0);
        pop("rd_b2", 8'hB2);
        pop("rd_c3", 8'hC3);
        pop("rd_d4", 8'hD4);
        idle_flags("drained");

        // Dropped push while full.
        push(8'h11);
        push(8'h22);
        push(8'h33);
        push(8'h44);
        push(8'hEE);
        check("drop_ovr", OVERRUN, 1);
        check("drop_intr", SSPRXINTR, 1);
        check("drop_head", PRDATA, 8'h11);
        pop("drop_rd11", 8'h11);
        check("drop_ovr_clr", OVERRUN, 0);
        check("drop_next", PRDATA, 8'h22);
        pop("drop_rd22", 8'h22);
        pop("drop_rd33", 8'h33);
        pop("drop_rd44", 8'h44);
        check("drop_empty", EMPTY, 1);

        // Push and pop in the same cycle while full.
        push(8'h61);
        push(8'h62);
        push(8'h63);
        push(8'h64);
        push_pop("pp_head", 8'h55, 8'h61);
        check("pp_intr", SSPRXINTR, 1);
        check("pp_ovr", OVERRUN, 0);
        pop("pp_rd62", 8'h62);
        pop("pp_rd63", 8'h63);
        pop("pp_rd64", 8'h64);
        pop("pp_rd55", 8'h55);
        check("pp_empty", EMPTY, 1);

        // Pointer wrap with up to three outstanding.
        push(8'h01);
        push(8'h02);
        push(8'h03);
        for (int i = 4; i <= 10; i++)
            push_pop($sformatf("wrap_%0d", i - 3), 8'(i), 8'(i - 3));
        pop("wrap_8", 8'h08);
        pop("wrap_9", 8'h09);
        pop("wrap_10", 8'h0A);
        check("wrap_empty", EMPTY, 1);

        // Ignored accesses.
        PSEL = 1'b1;
        step();
        idle_flags("rd_empty");
        push(8'h77);
        PSEL = 1'b0;
        step();
        check("nosel_data", PRDATA, 8'h77);
        PSEL   = 1'b1;
        PWRITE = 1'b1;
        step();
        check("write_data", PRDATA, 8'h77);
        check("write_empty", EMPTY, 0);
        pop("rd_77", 8'h77);
        idle_flags("after_77");

        // Asynchronous reset mid-cycle with overrun set.
        push(8'h91);
        push(8'h92);
        push(8'h93);
        push(8'h94);
        push(8'h95);
        check("pre_rst_ovr", OVERRUN, 1);
        #2;
        CLEAR_B = 1'b0;
        #1;
        idle_flags("async_rst");
        @(negedge PCLK);
        CLEAR_B = 1'b1;
        @(negedge PCLK);
        idle_flags("post_rst");
        push(8'h5A);
        check("post_rst_data", PRDATA, 8'h5A);
        pop("post_rst_rd", 8'h5A);
        check("post_rst_empty", EMPTY, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
